// File: rtl/ask_pkg.sv
// Shared types, defaults and width helper for the ASK demodulator.
package ask_pkg;

    localparam logic [15:0] MID_DEFAULT      = 16'h2710;
    localparam int          SYM_LOG2_DEFAULT = 9;

    typedef enum logic {
        IDLE,
        INTEG
    } state_t;

    // Wide enough for 2^sym_log2 full-scale 16-bit magnitudes.
    function automatic int acc_w(input int sym_log2);
        return 16 + sym_log2;
    endfunction

endpackage

// File: rtl/ask_symbol_integrator.sv
// Rectifies samples about the idle midpoint and integrates them over one symbol;
// flags the last sample of each symbol and exposes the running sum including it.
module ask_symbol_integrator
    import ask_pkg::*;
#(
    parameter logic [15:0] MID      = MID_DEFAULT,
    parameter int          SYM_LOG2 = SYM_LOG2_DEFAULT,
    parameter int          ACC_W    = acc_w(SYM_LOG2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      din,
    output logic [ACC_W-1:0] sum,
    output logic             sym_end
);

    logic [15:0]         mag;
    logic [ACC_W-1:0]    acc;
    logic [SYM_LOG2-1:0] cnt;

    assign mag     = (din >= MID) ? din - MID : MID - din;
    assign sum     = acc + ACC_W'(mag);
    assign sym_end = run && (cnt == '1);

    // The last sample closes the old symbol; the next cycle starts a fresh one.
    always_ff @(posedge clk) begin
        if (reset || !run || sym_end) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= sum;
            cnt <= cnt + SYM_LOG2'(1);
        end
    end

endmodule

// File: rtl/ask_demodulation.sv
// Non-coherent ASK demodulator: integrates rectified energy per symbol and slices it.
// Define ASK_DEMOD_AUTOTHR_EN for a threshold that tracks the last 1/0 energies.
module ask_demodulation
    import ask_pkg::*;
#(
    parameter logic [15:0] MID      = MID_DEFAULT,
    parameter int          SYM_LOG2 = SYM_LOG2_DEFAULT,
    parameter int unsigned THRESH   = 1_000_000,
    parameter int          ACC_W    = acc_w(SYM_LOG2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [15:0]      din,
    output logic             dout,
    output logic             dout_valid,
    output logic [ACC_W-1:0] energy
);

    localparam logic [ACC_W-1:0] THR_INIT = ACC_W'(THRESH);

    state_t           state, state_nxt;
    logic             run;
    logic [ACC_W-1:0] sum;
    logic             sym_end;
    logic [ACC_W-1:0] thr;
    logic             decide;

    ask_symbol_integrator #(
        .MID      (MID),
        .SYM_LOG2 (SYM_LOG2),
        .ACC_W    (ACC_W)
    ) u_integrator (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .din     (din),
        .sum     (sum),
        .sym_end (sym_end)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = INTEG;
            INTEG:   if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first enabled cycle in IDLE already carries sample 0 of the symbol.
    always_comb begin
        run = 1'b0;
        case (state)
            IDLE:    run = enable;
            INTEG:   run = enable;
            default: run = 1'b0;
        endcase
    end

    assign decide = sum > thr;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            energy     <= '0;
        end else begin
            dout_valid <= sym_end;
            if (sym_end) begin
                energy <= sum;
                dout   <= decide;
            end
        end
    end

`ifdef ASK_DEMOD_AUTOTHR_EN
    logic [ACC_W-1:0] e1, e0, e1_nxt, e0_nxt;
    logic [ACC_W:0]   thr_sum;

    // New threshold is the midpoint of the freshly updated 1/0 energy pair.
    always_comb begin
        e1_nxt = e1;
        e0_nxt = e0;
        if (decide) e1_nxt = sum;
        else        e0_nxt = sum;
        thr_sum = {1'b0, e1_nxt} + {1'b0, e0_nxt};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e1  <= THR_INIT;
            e0  <= THR_INIT;
            thr <= THR_INIT;
        end else if (sym_end) begin
            e1  <= e1_nxt;
            e0  <= e0_nxt;
            thr <= thr_sum[ACC_W:1];
        end
    end
`else
    assign thr = THR_INIT;
`endif

endmodule

// File: tb/tb_ask_demodulation.sv
// Self-checking bench for ask_demodulation: symbol table, corner sequences, and a
// per-cycle reference model built from sample counts and absolute-value sums.
module tb_ask_demodulation;
    import ask_pkg::*;

    localparam logic [15:0] MID   = MID_DEFAULT;
    localparam int          SYM   = 1 << SYM_LOG2_DEFAULT;
    localparam int          ACC_W = acc_w(SYM_LOG2_DEFAULT);
`ifdef ASK_DEMOD_AUTOTHR_EN
    localparam int unsigned TB_THRESH = 0;
`else
    localparam int unsigned TB_THRESH = 1_000_000;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [15:0]      din;
    logic             dout;
    logic             dout_valid;
    logic [ACC_W-1:0] energy;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;

    // Reference model state
    int     m_n;
    longint m_sum, m_energy, m_thr, m_e1, m_e0;
    bit     m_valid, m_dout;

    typedef struct {
        string       name;
        logic [15:0] even_s;
        logic [15:0] odd_s;
        logic [15:0] last_s;
        longint      exp_energy;
        bit          exp_dout;
    } sym_vec_t;

    sym_vec_t vecs[$];

    ask_demodulation #(
        .MID      (MID),
        .SYM_LOG2 (SYM_LOG2_DEFAULT),
        .THRESH   (TB_THRESH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .energy     (energy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit en, input logic [15:0] d);
        longint mag;
        if (r) begin
            m_n = 0; m_sum = 0; m_valid = 0; m_dout = 0; m_energy = 0;
            m_thr = TB_THRESH; m_e1 = TB_THRESH; m_e0 = TB_THRESH;
        end else begin
            m_valid = 0;
            if (!en) begin
                m_n = 0; m_sum = 0;
            end else begin
                mag = longint'(d) - longint'(MID);
                if (mag < 0) mag = -mag;
                m_sum += mag;
                m_n++;
                if (m_n == SYM) begin
                    m_valid  = 1;
                    m_energy = m_sum;
                    m_dout   = (m_sum > m_thr);
`ifdef ASK_DEMOD_AUTOTHR_EN
                    if (m_dout) m_e1 = m_sum;
                    else        m_e0 = m_sum;
                    m_thr = (m_e1 + m_e0) / 2;
`endif
                    m_n = 0; m_sum = 0;
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, then compare away from the edge.
    task automatic step(input bit r, input bit en, input logic [15:0] d);
        reset = r; enable = en; din = d;
        @(posedge clk);
        model(r, en, d);
        #1;
        check("dout_valid", longint'(dout_valid), longint'(m_valid));
        check("dout", longint'(dout), longint'(m_dout));
        check("energy", longint'(energy), m_energy);
        if (dout_valid) strobes++;
    endtask

    task automatic send_part(input logic [15:0] even_s, input logic [15:0] odd_s, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, (i % 2 == 0) ? even_s : odd_s);
    endtask

    function automatic sym_vec_t mk(input string name, input logic [15:0] e, input logic [15:0] o,
                                    input logic [15:0] l, input longint en, input bit dv);
        sym_vec_t v;
        v.name = name; v.even_s = e; v.odd_s = o; v.last_s = l;
        v.exp_energy = en; v.exp_dout = dv;
        return v;
    endfunction

    initial begin
        int s0;
        vecs.push_back(mk("idle_mid",   MID,    MID,    MID,    0,          0));
        vecs.push_back(mk("full_5000",  15000,  5000,   5000,   2_560_000,  1));
        vecs.push_back(mk("mid_after",  MID,    MID,    MID,    0,          0));
        vecs.push_back(mk("amp400k",    10781,  9219,   10909,  400_000,    0));
        vecs.push_back(mk("tie_1M",     11953,  8047,   12017,  1_000_000,  0));
        vecs.push_back(mk("pat_1a",     15000,  5000,   5000,   2_560_000,  1));
        vecs.push_back(mk("pat_0a",     MID,    MID,    MID,    0,          0));
        vecs.push_back(mk("pat_1b",     15000,  5000,   5000,   2_560_000,  1));
        vecs.push_back(mk("pat_1c",     15000,  5000,   5000,   2_560_000,  1));
        vecs.push_back(mk("pat_0b",     MID,    MID,    MID,    0,          0));
        vecs.push_back(mk("above_1M",   11953,  8047,   12018,  1_000_001,  1));
        vecs.push_back(mk("max_din",    16'hFFFF, 16'hFFFF, 16'hFFFF, 28_433_920, 1));
        vecs.push_back(mk("zero_din",   0,      0,      0,      5_120_000,  1));

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, MID);
        check("rst_dout", longint'(dout), 0);
        check("rst_dout_valid", longint'(dout_valid), 0);
        check("rst_energy", longint'(energy), 0);

        // Back-to-back symbols from the table
        strobes = 0;
        foreach (vecs[k]) begin
            send_part(vecs[k].even_s, vecs[k].odd_s, SYM - 1);
            check({vecs[k].name, "_no_early_strobe"}, longint'(strobes), longint'(k));
            step(1'b0, 1'b1, vecs[k].last_s);
            check({vecs[k].name, "_valid"}, longint'(dout_valid), 1);
            check({vecs[k].name, "_energy"}, longint'(energy), vecs[k].exp_energy);
`ifdef ASK_DEMOD_AUTOTHR_EN
            if (vecs[k].name == "amp400k") check("autothr_thr", longint'(u_dut.thr), 1_480_000);
`else
            check({vecs[k].name, "_dout"}, longint'(dout), longint'(vecs[k].exp_dout));
`endif
        end
        check("table_strobe_count", longint'(strobes), longint'(vecs.size()));

        // Enable drop at cnt=300 for 10 cycles: partial symbol discarded, outputs hold
        s0 = strobes;
        send_part(15000, 5000, 300);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 15000);
        send_part(MID, MID, SYM - 1);
        check("drop_no_strobe", longint'(strobes), longint'(s0));
        check("drop_energy_hold", longint'(energy), 5_120_000);
        step(1'b0, 1'b1, MID);
        check("drop_strobe_after_512", longint'(strobes), longint'(s0 + 1));
        check("drop_new_energy", longint'(energy), 0);

        // Enable falling on the last-sample cycle: no strobe
        s0 = strobes;
        send_part(15000, 5000, SYM - 1);
        step(1'b0, 1'b0, 5000);
        check("lastfall_no_valid", longint'(dout_valid), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, MID);
        check("lastfall_no_strobe", longint'(strobes), longint'(s0));

        // Mid-symbol reset, then reset on the strobe cycle
        send_part(15000, 5000, 100);
        step(1'b1, 1'b1, MID);
        check("midrst_energy", longint'(energy), 0);
        send_part(15000, 5000, SYM);
        check("rststrobe_valid", longint'(dout_valid), 1);
        check("rststrobe_energy", longint'(energy), 2_560_000);
        step(1'b1, 1'b1, 15000);
        check("rststrobe_dout", longint'(dout), 0);
        check("rststrobe_dout_valid", longint'(dout_valid), 0);
        check("rststrobe_energy0", longint'(energy), 0);
        check("rststrobe_state", longint'(u_dut.state), longint'(IDLE));
        s0 = strobes;
        send_part(15000, 5000, SYM);
        check("post_rst_strobe", longint'(strobes), longint'(s0 + 1));
        check("post_rst_energy", longint'(energy), 2_560_000);

        // Randomized symbols with occasional enable glitches against the model
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < SYM; i++) begin
                logic [15:0] d;
                d = 16'($urandom);
                step(1'b0, ($urandom_range(0, 299) != 0), d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
